prbs_checker: RTL and testbench
===============================

// Module: prbs_checker
// PURPOSE
//  Receive-side checker for the 32-bit Fibonacci LFSR PRBS stream (taps 31,20,1,0, MSB-first serial out).
//  Self-synchronises to an incoming serial bit stream, declares lock, then counts bit errors.
//  Sits at the far end of the serial link, opposite the LFSR generator; used for link BER test.
// PARAMETERS
//  LOCK_COUNT  64   consecutive matching bits needed in VERIFY before LOCKED (>=1)
//  WINDOW      256  valid bits per loss-of-lock evaluation window (power of 2)
//  ERR_THRESH  8    errors within one WINDOW that force loss of lock (>=1)
//  CNT_W       16   width of err_count / bit_count (saturating)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  rx_bit     in   1      received serial bit, sampled when rx_valid=1
//  rx_valid   in   1      qualifies rx_bit (the generator's shift strobe); gaps allowed
//  resync     in   1      sync pulse: force re-acquisition
//  clr_cnt    in   1      sync pulse: clear err_count and bit_count
//  locked     out  1      checker locked to the PRBS stream
//  err_pulse  out  1      one-cycle pulse per mismatched bit while LOCKED
//  sync_lost  out  1      one-cycle pulse when LOCKED -> SEED via threshold
//  err_count  out  CNT_W  errors counted while LOCKED, saturating
//  bit_count  out  CNT_W  bits checked while LOCKED, saturating
// BEHAVIOUR
//  Reset: all outputs 0, state SEED, history H=0, all internal counters 0.
//  H[31:0]: H[0] = newest bit. Shift on each rx_valid: H <= {H[30:0], in}.
//  Prediction: p = H[31]^H[20]^H[1]^H[0]. Mismatch: rx_bit != p.
//  States (advance only on rx_valid=1 cycles unless noted):
//   SEED   : shift rx_bit into H; fill_cnt++. At the 32nd bit, go to VERIFY if {H[30:0],rx_bit}!=0.
//            Otherwise, restart fill (fill_cnt=0). An all-zero stream never locks.
//   VERIFY : compare rx_bit vs p; shift rx_bit in. Match -> match_cnt++.
//            At LOCK_COUNT matches -> LOCKED. Mismatch -> SEED (fill_cnt=0, match_cnt=0).
//   LOCKED : compare rx_bit vs p; shift p in, not rx_bit. One line error = exactly one err_pulse.
//            bit_count++ per bit. On mismatch, err_count++ and win_err++.
//            win_cnt++ per bit. If win_err reaches ERR_THRESH -> SEED, sync_lost=1.
//            After the bit that completes WINDOW, win_cnt=0 and win_err=0.
//            Threshold is evaluated including that bit, before the window clears.
//  Timing: all outputs registered. err_pulse/sync_lost are high in the cycle after the sampling edge.
//  locked rises at the edge sampling the LOCK_COUNT-th match and falls at the edge entering SEED.
//  Clean-stream lock latency = 32 + LOCK_COUNT valid bits.
//  Threshold-hitting error: err_pulse, sync_lost and locked fall occur at the same edge; the error is counted.
//  rx_valid=0: no state, counter or H change; pulses low.
//  resync=1: next edge -> SEED, clears fill/match/win counters; locked=0; counts kept; overrides rx_valid.
//  clr_cnt=1: err_count=bit_count=0. Wins over a same-cycle increment, and that event is not counted.
//  Counters saturate at all-ones, no wrap. win_cnt wraps naturally (WINDOW power of 2).
//  rst_n asserted mid-stream: immediate return to reset values. Re-acquisition needs a full 32+LOCK_COUNT bits.
// TESTING
//  1. Generator seed 0x0000_0001, rx_valid=1 every cycle -> locked rises after 96th bit.
//     err_count=0, bit_count=904 after 1000 bits.
//  2. Same stream with rx_valid randomly 50% -> lock after 96 valid bits; no errors; outputs hold during gaps.
//  3. After lock, invert one bit -> single err_pulse, err_count=1, locked stays 1.
//     Verifies no error multiplication.
//  4. After lock, invert 8 bits within 256 -> sync_lost and locked=0 on 8th err_pulse edge.
//     err_count=8; relock after 96 clean bits.
//  5. 7 errors in window 1, 7 in window 2 -> stays locked, err_count=14.
//     Constant-0 stream from reset -> locked never rises.
//  6. resync mid-lock -> locked=0 next edge, counts kept. clr_cnt on an error cycle -> err_count=0.
//     rst_n low mid-lock -> all outputs 0 immediately.

Source files
------------

// File: rtl/prbs_checker.sv
// prbs_checker
//   Receive-side checker for the 32-bit Fibonacci LFSR PRBS stream
//   (taps 31,20,1,0, MSB-first). Self-synchronises to the serial stream,
//   declares lock, then counts bit errors for link BER measurement.
// Ports
//   i_clk        rising-edge clock
//   i_rst_n      asynchronous active-low reset
//   i_rx_bit     received serial bit, sampled when i_rx_valid=1
//   i_rx_valid   qualifies i_rx_bit (gaps allowed)
//   i_resync     pulse: force re-acquisition (overrides i_rx_valid)
//   i_clr_cnt    pulse: clear o_err_count and o_bit_count
//   o_locked     checker locked to the PRBS stream
//   o_err_pulse  one-cycle pulse per mismatched bit while locked
//   o_sync_lost  one-cycle pulse on loss of lock via error threshold
//   o_err_count  saturating error count while locked
//   o_bit_count  saturating checked-bit count while locked
module prbs_checker #(
    parameter int LOCK_COUNT = 64,
    parameter int WINDOW     = 256,
    parameter int ERR_THRESH = 8,
    parameter int CNT_W      = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_rx_bit,
    input  logic             i_rx_valid,
    input  logic             i_resync,
    input  logic             i_clr_cnt,
    output logic             o_locked,
    output logic             o_err_pulse,
    output logic             o_sync_lost,
    output logic [CNT_W-1:0] o_err_count,
    output logic [CNT_W-1:0] o_bit_count
);
    localparam int MW = $clog2(LOCK_COUNT + 1);
    localparam int WW = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int EW = $clog2(ERR_THRESH + 1);

    typedef enum logic [1:0] {SEED, VERIFY, LOCKED} state_t;

    state_t           r_state, w_next;
    logic [31:0]      r_h;
    logic [4:0]       r_fill;
    logic [MW-1:0]    r_match;
    logic [WW-1:0]    r_win_cnt;
    logic [EW-1:0]    r_win_err;
    logic [CNT_W-1:0] r_err_cnt, r_bit_cnt;
    logic             r_locked, r_err_pulse, r_sync_lost;

    logic        w_adv, w_pred, w_mis, w_fill_done, w_match_done, w_thresh, w_win_last;
    logic        w_err_pulse, w_sync_lost, w_locked;
    logic [31:0] w_shift_in;

    assign w_adv        = i_rx_valid & ~i_resync;
    assign w_pred       = r_h[31] ^ r_h[20] ^ r_h[1] ^ r_h[0];
    assign w_mis        = i_rx_bit ^ w_pred;
    assign w_shift_in   = {r_h[30:0], i_rx_bit};
    assign w_fill_done  = (r_fill == 5'd31);
    assign w_match_done = (r_match == MW'(LOCK_COUNT - 1));
    // Threshold is judged with the current bit included, before any window clear.
    assign w_thresh     = (r_win_err == EW'(ERR_THRESH - 1));
    assign w_win_last   = (r_win_cnt == WW'(WINDOW - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= SEED;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        if (i_resync) begin
            w_next = SEED;
        end else if (i_rx_valid) begin
            case (r_state)
                SEED:    if (w_fill_done && (w_shift_in != 32'd0)) w_next = VERIFY;
                VERIFY:  if (w_mis) w_next = SEED;
                         else if (w_match_done) w_next = LOCKED;
                LOCKED:  if (w_mis && w_thresh) w_next = SEED;
                default: w_next = SEED;
            endcase
        end
    end

    // Output decode (registered below)
    always_comb begin
        w_err_pulse = w_adv && (r_state == LOCKED) && w_mis;
        w_sync_lost = w_err_pulse && w_thresh;
        w_locked    = (w_next == LOCKED);
    end

    // History, acquisition and window counters
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_h       <= '0;
            r_fill    <= '0;
            r_match   <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (i_resync) begin
            r_fill    <= '0;
            r_match   <= '0;
            r_win_cnt <= '0;
            r_win_err <= '0;
        end else if (i_rx_valid) begin
            case (r_state)
                SEED: begin
                    r_h    <= w_shift_in;
                    r_fill <= w_fill_done ? 5'd0 : r_fill + 5'd1;
                end
                VERIFY: begin
                    r_h <= w_shift_in;
                    if (w_mis) begin
                        r_fill  <= '0;
                        r_match <= '0;
                    end else begin
                        r_match <= w_match_done ? '0 : r_match + MW'(1);
                    end
                end
                LOCKED: begin
                    // Feed back the prediction so a line error cannot propagate.
                    r_h <= {r_h[30:0], w_pred};
                    if (w_sync_lost || w_win_last) begin
                        r_win_cnt <= '0;
                        r_win_err <= '0;
                    end else begin
                        r_win_cnt <= r_win_cnt + WW'(1);
                        r_win_err <= r_win_err + EW'(w_mis);
                    end
                end
                default: ;
            endcase
        end
    end

    // Statistics counters and registered outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_err_cnt   <= '0;
            r_bit_cnt   <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_sync_lost <= 1'b0;
        end else begin
            r_locked    <= w_locked;
            r_err_pulse <= w_err_pulse;
            r_sync_lost <= w_sync_lost;
            if (i_clr_cnt) begin
                r_err_cnt <= '0;
                r_bit_cnt <= '0;
            end else if (w_adv && (r_state == LOCKED)) begin
                if (r_bit_cnt != '1) r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                if (w_mis && (r_err_cnt != '1)) r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
        end
    end

    assign o_locked    = r_locked;
    assign o_err_pulse = r_err_pulse;
    assign o_sync_lost = r_sync_lost;
    assign o_err_count = r_err_cnt;
    assign o_bit_count = r_bit_cnt;
endmodule

// File: tb/tb_prbs_checker.sv
module tb_prbs_checker;
    localparam int LOCK_COUNT = 64;
    localparam int WINDOW     = 256;
    localparam int ERR_THRESH = 8;
    localparam int CNT_W      = 16;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rx_bit = 1'b0, rx_valid = 1'b0, resync = 1'b0, clr_cnt = 1'b0;
    logic locked, err_pulse, sync_lost;
    logic [CNT_W-1:0] err_count, bit_count;

    int checks = 0;
    int errors = 0;

    prbs_checker #(.LOCK_COUNT(LOCK_COUNT), .WINDOW(WINDOW), .ERR_THRESH(ERR_THRESH), .CNT_W(CNT_W)) dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_rx_bit(rx_bit), .i_rx_valid(rx_valid),
        .i_resync(resync), .i_clr_cnt(clr_cnt), .o_locked(locked), .o_err_pulse(err_pulse),
        .o_sync_lost(sync_lost), .o_err_count(err_count), .o_bit_count(bit_count)
    );

    always #5 clk = ~clk;

    // Generator: stream x obeys x[t+32] = x[t]^x[t+11]^x[t+30]^x[t+31];
    // g holds the next 32 stream bits, g[0] being the next to send.
    bit g[$];

    task automatic gen_seed(input logic [31:0] s);
        g = {};
        for (int i = 31; i >= 0; i--) g.push_back(s[i]);
    endtask

    task automatic gen_next(output bit o);
        o = g[0];
        g.push_back(g[0] ^ g[11] ^ g[30] ^ g[31]);
        void'(g.pop_front());
    endtask

    // Reference model: last 32 bits seen (index 0 newest), mode 0/1/2 = seed/verify/locked.
    bit hist[$];
    int m_mode, m_fill, m_match, m_wcnt, m_werr, m_ec, m_bc;
    bit m_locked, m_err, m_lost;

    task automatic model_reset();
        hist = {};
        for (int i = 0; i < 32; i++) hist.push_back(1'b0);
        m_mode = 0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
        m_ec = 0; m_bc = 0; m_locked = 0; m_err = 0; m_lost = 0;
    endtask

    task automatic hpush(input bit x);
        hist.push_front(x);
        void'(hist.pop_back());
    endtask

    task automatic model_update(input bit b, input bit v, input bit rs, input bit cl);
        bit p;
        bit nz;
        m_err = 0; m_lost = 0;
        p = hist[31] ^ hist[20] ^ hist[1] ^ hist[0];
        if (rs) begin
            m_mode = 0; m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0; m_locked = 0;
        end else if (v) begin
            if (m_mode == 0) begin
                hpush(b);
                m_fill++;
                if (m_fill == 32) begin
                    m_fill = 0;
                    nz = 0;
                    for (int i = 0; i < 32; i++) nz |= hist[i];
                    if (nz) m_mode = 1;
                end
            end else if (m_mode == 1) begin
                hpush(b);
                if (b == p) begin
                    m_match++;
                    if (m_match == LOCK_COUNT) begin m_mode = 2; m_locked = 1; m_match = 0; end
                end else begin
                    m_mode = 0; m_fill = 0; m_match = 0;
                end
            end else begin
                hpush(p);
                if (m_bc < CMAX) m_bc++;
                m_wcnt++;
                if (b != p) begin
                    m_err = 1;
                    if (m_ec < CMAX) m_ec++;
                    m_werr++;
                end
                if (m_werr >= ERR_THRESH) begin
                    m_lost = 1; m_mode = 0; m_locked = 0;
                    m_fill = 0; m_match = 0; m_wcnt = 0; m_werr = 0;
                end else if (m_wcnt == WINDOW) begin
                    m_wcnt = 0; m_werr = 0;
                end
            end
        end
        if (cl) begin m_ec = 0; m_bc = 0; end
    endtask

    // Drive one cycle; outputs are stable and model updated on return (posedge + 1).
    task automatic step(input bit b, input bit v, input bit rs, input bit cl);
        @(negedge clk);
        rx_bit = b; rx_valid = v; resync = rs; clr_cnt = cl;
        @(posedge clk);
        model_update(b, v, rs, cl);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; rx_valid = 0; resync = 0; clr_cnt = 0; rx_bit = 0;
        model_reset();
        #12;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic lock_up(input logic [31:0] s);
        bit b;
        do_reset();
        gen_seed(s);
        for (int n = 0; n < 32 + LOCK_COUNT; n++) begin
            gen_next(b);
            step(b, 1, 0, 0);
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL lock_up locked got %b want 1", locked); end
    endtask

    task automatic test_reset();
        do_reset();
        step(1'b1, 0, 0, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL rst_locked got %b want 0", locked); end
        checks++; if (err_pulse !== 1'b0) begin errors++; $display("FAIL rst_err_pulse got %b want 0", err_pulse); end
        checks++; if (sync_lost !== 1'b0) begin errors++; $display("FAIL rst_sync_lost got %b want 0", sync_lost); end
        checks++; if (err_count !== '0) begin errors++; $display("FAIL rst_err_count got %0d want 0", err_count); end
        checks++; if (bit_count !== '0) begin errors++; $display("FAIL rst_bit_count got %0d want 0", bit_count); end
    endtask

    task automatic test_clean_lock();
        bit b;
        int lock_at = 0;
        do_reset();
        gen_seed(32'h0000_0001);
        for (int n = 1; n <= 1000; n++) begin
            gen_next(b);
            step(b, 1, 0, 0);
            if (locked === 1'b1 && lock_at == 0) lock_at = n;
        end
        checks++; if (lock_at != 32 + LOCK_COUNT) begin errors++; $display("FAIL clean_lock_at got %0d want %0d", lock_at, 32 + LOCK_COUNT); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL clean_err_count got %0d want 0", err_count); end
        checks++; if (bit_count !== 16'd904) begin errors++; $display("FAIL clean_bit_count got %0d want 904", bit_count); end
    endtask

    task automatic test_gaps();
        bit b;
        int nvalid = 0, lock_at = 0, cyc = 0, gap_bad = 0;
        logic pl;
        logic [CNT_W-1:0] pe, pb;
        do_reset();
        gen_seed(32'h0000_0001);
        while (nvalid < 200 && cyc < 3000) begin
            bit v;
            v = $urandom_range(1, 0);
            if (v) gen_next(b); else b = $urandom_range(1, 0);
            pl = locked; pe = err_count; pb = bit_count;
            step(b, v, 0, 0);
            cyc++;
            if (v) begin
                nvalid++;
                if (locked === 1'b1 && lock_at == 0) lock_at = nvalid;
            end else if (locked !== pl || err_count !== pe || bit_count !== pb || err_pulse !== 1'b0) begin
                gap_bad++;
            end
        end
        checks++; if (nvalid != 200) begin errors++; $display("FAIL gaps_budget got %0d want 200", nvalid); end
        checks++; if (lock_at != 32 + LOCK_COUNT) begin errors++; $display("FAIL gaps_lock_at got %0d want %0d", lock_at, 32 + LOCK_COUNT); end
        checks++; if (gap_bad != 0) begin errors++; $display("FAIL gaps_hold got %0d want 0", gap_bad); end
        checks++; if (bit_count !== 16'd104) begin errors++; $display("FAIL gaps_bit_count got %0d want 104", bit_count); end
        checks++; if (err_count !== 16'd0) begin errors++; $display("FAIL gaps_err_count got %0d want 0", err_count); end
    endtask

    task automatic test_single_error();
        bit b;
        int pulses = 0;
        lock_up(32'h0000_0001);
        for (int i = 0; i < 51; i++) begin
            gen_next(b);
            step((i == 20) ? ~b : b, 1, 0, 0);
            if (err_pulse === 1'b1) pulses++;
        end
        checks++; if (pulses != 1) begin errors++; $display("FAIL single_pulses got %0d want 1", pulses); end
        checks++; if (err_count !== 16'd1) begin errors++; $display("FAIL single_err_count got %0d want 1", err_count); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL single_locked got %b want 1", locked); end
        checks++; if (bit_count !== 16'd51) begin errors++; $display("FAIL single_bit_count got %0d want 51", bit_count); end
    endtask

    task automatic test_threshold();
        bit b;
        int lost = 0;
        lock_up(32'h1234_5678);
        for (int k = 0; k < ERR_THRESH; k++) begin
            for (int i = 0; i < 10; i++) begin gen_next(b); step(b, 1, 0, 0); end
            gen_next(b);
            step(~b, 1, 0, 0);
            if (sync_lost === 1'b1) lost++;
            if (k == ERR_THRESH - 2) begin
                checks++; if (locked !== 1'b1) begin errors++; $display("FAIL thr_pre_locked got %b want 1", locked); end
            end
        end
        checks++; if (sync_lost !== 1'b1 || err_pulse !== 1'b1) begin errors++; $display("FAIL thr_pulses got lost=%b err=%b want 1 1", sync_lost, err_pulse); end
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL thr_locked got %b want 0", locked); end
        checks++; if (err_count !== 16'(ERR_THRESH)) begin errors++; $display("FAIL thr_err_count got %0d want %0d", err_count, ERR_THRESH); end
        for (int i = 1; i <= 32 + LOCK_COUNT; i++) begin
            gen_next(b);
            step(b, 1, 0, 0);
            if (sync_lost === 1'b1) lost++;
            if (i == 31 + LOCK_COUNT) begin
                checks++; if (locked !== 1'b0) begin errors++; $display("FAIL thr_early_relock got %b want 0", locked); end
            end
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL thr_relock got %b want 1", locked); end
        checks++; if (lost != 1) begin errors++; $display("FAIL thr_lost_count got %0d want 1", lost); end
    endtask

    task automatic test_window_boundary();
        bit b;
        int lost = 0, lk = 0;
        lock_up(32'hDEAD_BEEF);
        // 7 errors at the tail of window 1, 7 at the head of window 2.
        for (int i = 0; i < 2 * WINDOW; i++) begin
            gen_next(b);
            step((i >= WINDOW - 7 && i < WINDOW + 7) ? ~b : b, 1, 0, 0);
            if (sync_lost === 1'b1) lost++;
        end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL win_locked got %b want 1", locked); end
        checks++; if (err_count !== 16'd14) begin errors++; $display("FAIL win_err_count got %0d want 14", err_count); end
        checks++; if (lost != 0) begin errors++; $display("FAIL win_lost got %0d want 0", lost); end
        do_reset();
        for (int i = 0; i < 500; i++) begin
            step(1'b0, 1, 0, 0);
            if (locked === 1'b1) lk++;
        end
        checks++; if (lk != 0) begin errors++; $display("FAIL zero_stream_locked got %0d want 0", lk); end
    endtask

    task automatic test_resync_clr_rst();
        bit b;
        lock_up(32'h0BAD_F00D);
        for (int i = 0; i < 10; i++) begin gen_next(b); step((i == 3 || i == 7) ? ~b : b, 1, 0, 0); end
        gen_next(b);
        step(b, 1, 1, 0);
        checks++; if (locked !== 1'b0) begin errors++; $display("FAIL resync_locked got %b want 0", locked); end
        checks++; if (err_count !== 16'd2 || bit_count !== 16'd10) begin errors++; $display("FAIL resync_counts got %0d/%0d want 2/10", err_count, bit_count); end
        for (int i = 0; i < 32 + LOCK_COUNT; i++) begin gen_next(b); step(b, 1, 0, 0); end
        checks++; if (locked !== 1'b1) begin errors++; $display("FAIL resync_relock got %b want 1", locked); end
        gen_next(b);
        step(~b, 1, 0, 1);
        checks++; if (err_count !== 16'd0 || bit_count !== 16'd0) begin errors++; $display("FAIL clr_counts got %0d/%0d want 0/0", err_count, bit_count); end
        checks++; if (err_pulse !== 1'b1) begin errors++; $display("FAIL clr_err_pulse got %b want 1", err_pulse); end
        for (int i = 0; i < 6; i++) begin gen_next(b); step((i == 5) ? ~b : b, 1, 0, 0); end
        checks++; if (err_count !== 16'd1 || bit_count !== 16'd6) begin errors++; $display("FAIL post_clr_counts got %0d/%0d want 1/6", err_count, bit_count); end
        rst_n = 1'b0;
        #1;
        checks++; if ({locked, err_pulse, sync_lost} !== 3'b000 || err_count !== '0 || bit_count !== '0) begin
            errors++; $display("FAIL async_rst got l=%b e=%b s=%b ec=%0d bc=%0d want all 0", locked, err_pulse, sync_lost, err_count, bit_count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        bit b, v, rs, cl, inj;
        int bad = 0;
        do_reset();
        gen_seed($urandom | 32'h1);
        for (int n = 0; n < 4000; n++) begin
            v   = ($urandom_range(3, 0) != 0);
            inj = ($urandom_range(63, 0) == 0);
            rs  = ($urandom_range(599, 0) == 0);
            cl  = ($urandom_range(399, 0) == 0);
            if (v) begin gen_next(b); b = b ^ inj; end else b = $urandom_range(1, 0);
            step(b, v, rs, cl);
            checks++;
            if (locked !== m_locked || err_pulse !== m_err || sync_lost !== m_lost ||
                err_count !== 16'(m_ec) || bit_count !== 16'(m_bc)) begin
                errors++;
                if (bad < 10) $display("FAIL random cyc %0d got l=%b e=%b s=%b ec=%0d bc=%0d want l=%b e=%b s=%b ec=%0d bc=%0d",
                    n, locked, err_pulse, sync_lost, err_count, bit_count, m_locked, m_err, m_lost, m_ec, m_bc);
                bad++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_lock();
        test_gaps();
        test_single_error();
        test_threshold();
        test_window_boundary();
        test_resync_clr_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
